// File: rtl/pipeline_hazard_ctrl.sv
// rtl/pipeline_hazard_ctrl.sv - pipeline forwarding, stall/flush and data-memory wait/timeout controller
// Optional stall-cycle performance counter enabled by defining HAZARD_PERF_EN.
module pipeline_hazard_ctrl #(
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] RA1D,
    input  logic [3:0] RA2D,
    input  logic [3:0] RA1E,
    input  logic [3:0] RA2E,
    input  logic [3:0] WA3E,
    input  logic [3:0] WA3M,
    input  logic [3:0] WA3W,
    input  logic       RegWriteM,
    input  logic       RegWriteW,
    input  logic       MemtoRegE,
    input  logic       PCSrcD,
    input  logic       PCSrcE,
    input  logic       PCSrcM,
    input  logic       PCSrcW,
    input  logic       BranchTakenE,
    input  logic       MemAccessM,
    input  logic       mem_ready,
    output logic [1:0] ForwardAE,
    output logic [1:0] ForwardBE,
    output logic       StallF,
    output logic       StallD,
    output logic       StallE,
    output logic       StallM,
    output logic       FlushD,
    output logic       FlushE,
    output logic       FlushW,
    output logic       mem_err
`ifdef HAZARD_PERF_EN
    ,
    output logic [31:0] stall_cnt
`endif
);

    localparam logic [7:0] TIMEOUT = 8'(MEM_TIMEOUT);

    typedef enum logic {
        IDLE,
        WAIT
    } state_t;

    state_t     state_q;
    logic [7:0] cnt_q;
    logic       mem_err_q;

    logic ldr_stall;
    logic pc_wr_pending;
    logic mem_stall;

    // R15 is the PC; its value comes from the fetch path, never from a later stage.
    always_comb begin
        ForwardAE = 2'b00;
        if (RA1E != 4'd15) begin
            if (RegWriteM && (WA3M == RA1E))
                ForwardAE = 2'b10;
            else if (RegWriteW && (WA3W == RA1E))
                ForwardAE = 2'b01;
        end
    end

    always_comb begin
        ForwardBE = 2'b00;
        if (RA2E != 4'd15) begin
            if (RegWriteM && (WA3M == RA2E))
                ForwardBE = 2'b10;
            else if (RegWriteW && (WA3W == RA2E))
                ForwardBE = 2'b01;
        end
    end

    assign ldr_stall     = MemtoRegE && ((WA3E == RA1D) || (WA3E == RA2D));
    assign pc_wr_pending = PCSrcD || PCSrcE || PCSrcM;

    // The timeout cycle itself releases the pipeline so the aborted access retires.
    assign mem_stall = MemAccessM && !mem_ready
                       && !((state_q == WAIT) && (cnt_q == TIMEOUT));

    always_comb begin
        StallF = 1'b0;
        StallD = 1'b0;
        StallE = 1'b0;
        StallM = 1'b0;
        FlushD = 1'b0;
        FlushE = 1'b0;
        FlushW = 1'b0;
        if (mem_stall) begin
            StallF = 1'b1;
            StallD = 1'b1;
            StallE = 1'b1;
            StallM = 1'b1;
            FlushW = 1'b1;
        end else begin
            StallF = ldr_stall || pc_wr_pending;
            StallD = ldr_stall;
            FlushD = pc_wr_pending || PCSrcW || BranchTakenE;
            FlushE = ldr_stall || BranchTakenE;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            cnt_q     <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            mem_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (MemAccessM && !mem_ready) begin
                        state_q <= WAIT;
                        cnt_q   <= 8'd1;
                    end
                end
                WAIT: begin
                    if (mem_ready) begin
                        state_q <= IDLE;
                        cnt_q   <= 8'd0;
                    end else if (cnt_q == TIMEOUT) begin
                        state_q   <= IDLE;
                        cnt_q     <= 8'd0;
                        mem_err_q <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= 8'd0;
                end
            endcase
        end
    end

    assign mem_err = mem_err_q;

`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt_q;
    logic [31:0] stall_cnt_d;

    assign stall_cnt_d = (StallF || StallM) ? stall_cnt_q + 32'd1 : stall_cnt_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            stall_cnt_q <= 32'd0;
        else
            stall_cnt_q <= stall_cnt_d;
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// tb/tb_pipeline_hazard_ctrl.sv - directed scoreboard bench for pipeline_hazard_ctrl (MEM_TIMEOUT=4)
module tb_pipeline_hazard_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W;
    logic       RegWriteM, RegWriteW, MemtoRegE;
    logic       PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
    logic       MemAccessM, mem_ready;
    logic [1:0] ForwardAE, ForwardBE;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW, mem_err;
`ifdef HAZARD_PERF_EN
    logic [31:0] stall_cnt;
`endif

    pipeline_hazard_ctrl #(.MEM_TIMEOUT(4)) dut (
        .clk(clk), .reset(reset),
        .RA1D(RA1D), .RA2D(RA2D), .RA1E(RA1E), .RA2E(RA2E),
        .WA3E(WA3E), .WA3M(WA3M), .WA3W(WA3W),
        .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .MemtoRegE(MemtoRegE),
        .PCSrcD(PCSrcD), .PCSrcE(PCSrcE), .PCSrcM(PCSrcM), .PCSrcW(PCSrcW),
        .BranchTakenE(BranchTakenE), .MemAccessM(MemAccessM), .mem_ready(mem_ready),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushD(FlushD), .FlushE(FlushE), .FlushW(FlushW), .mem_err(mem_err)
`ifdef HAZARD_PERF_EN
        , .stall_cnt(stall_cnt)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        string      tag;
        logic [1:0] fa;
        logic [1:0] fb;
        logic [6:0] ctl;
        logic       me;
    } exp_t;

    exp_t        sb[$];
    int          checks = 0;
    int          errors = 0;
    logic [31:0] model_cnt = 32'd0;

    localparam logic [6:0] NONE = 7'b0000_000;
    localparam logic [6:0] MEMS = 7'b1111_001;
    localparam logic [6:0] LDR  = 7'b1100_010;
    localparam logic [6:0] PCD  = 7'b1000_100;
    localparam logic [6:0] FLD  = 7'b0000_100;
    localparam logic [6:0] BR   = 7'b0000_110;

    task automatic clr();
        {RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W} = '0;
        {RegWriteM, RegWriteW, MemtoRegE} = '0;
        {PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE} = '0;
        MemAccessM = 1'b0;
        mem_ready  = 1'b0;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic set_reset(input logic v);
        reset = v;
        if (v) model_cnt = 32'd0;
    endtask

    // Expected values are queued with the stimulus and compared once outputs settle.
    task automatic expect_(input string tag, input logic [1:0] fa, input logic [1:0] fb,
                           input logic [6:0] ctl, input logic me);
        exp_t e;
        logic [6:0] obs;
        e.tag = tag; e.fa = fa; e.fb = fb; e.ctl = ctl; e.me = me;
        sb.push_back(e);
        #2;
        e = sb.pop_front();
        obs = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};
        checks++;
        assert (ForwardAE === e.fa) else begin
            errors++;
            $error("FAIL %s ForwardAE observed %b expected %b", e.tag, ForwardAE, e.fa);
        end
        checks++;
        assert (ForwardBE === e.fb) else begin
            errors++;
            $error("FAIL %s ForwardBE observed %b expected %b", e.tag, ForwardBE, e.fb);
        end
        checks++;
        assert (obs === e.ctl) else begin
            errors++;
            $error("FAIL %s stall/flush {F,D,E,M,FD,FE,FW} observed %b expected %b", e.tag, obs, e.ctl);
        end
        checks++;
        assert (mem_err === e.me) else begin
            errors++;
            $error("FAIL %s mem_err observed %b expected %b", e.tag, mem_err, e.me);
        end
`ifdef HAZARD_PERF_EN
        checks++;
        assert (stall_cnt === model_cnt) else begin
            errors++;
            $error("FAIL %s stall_cnt observed %0d expected %0d", e.tag, stall_cnt, model_cnt);
        end
`endif
        if (!reset && (e.ctl[6] || e.ctl[3])) model_cnt = model_cnt + 32'd1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        clr();
        set_reset(1'b1);
        #1;
        expect_("reset_idle", 2'b00, 2'b00, NONE, 1'b0);
        tick();
        RegWriteM = 1'b1; WA3M = 4'd3; RA1E = 4'd3; MemAccessM = 1'b1;
        expect_("reset_comb", 2'b10, 2'b00, MEMS, 1'b0);
        tick(); clr(); set_reset(1'b0);
        expect_("post_reset", 2'b00, 2'b00, NONE, 1'b0);

        // forwarding
        tick();
        RegWriteM = 1'b1; WA3M = 4'd3; RegWriteW = 1'b1; WA3W = 4'd3; RA1E = 4'd3;
        expect_("fwd_mem_prio", 2'b10, 2'b00, NONE, 1'b0);
        tick(); RA1E = 4'd15;
        expect_("fwd_r15", 2'b00, 2'b00, NONE, 1'b0);
        tick(); RegWriteM = 1'b0; RA1E = 4'd3; RA2E = 4'd3;
        expect_("fwd_wb", 2'b01, 2'b01, NONE, 1'b0);
        tick(); clr();
        RegWriteM = 1'b1; WA3M = 4'd7; RegWriteW = 1'b1; WA3W = 4'd7; RA1E = 4'd2; RA2E = 4'd7;
        expect_("fwd_b_mem", 2'b00, 2'b10, NONE, 1'b0);
        tick(); clr();
        RegWriteM = 1'b1; WA3M = 4'd15; RegWriteW = 1'b1; WA3W = 4'd15; RA1E = 4'd15; RA2E = 4'd15;
        expect_("fwd_r15_both", 2'b00, 2'b00, NONE, 1'b0);

        // load-use, PC write, branch
        tick(); clr(); MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        expect_("ldr_stall", 2'b00, 2'b00, LDR, 1'b0);
        tick(); MemtoRegE = 1'b0;
        expect_("ldr_done", 2'b00, 2'b00, NONE, 1'b0);
        tick(); clr(); PCSrcD = 1'b1;
        expect_("pc_wr_d", 2'b00, 2'b00, PCD, 1'b0);
        tick(); clr(); PCSrcM = 1'b1;
        expect_("pc_wr_m", 2'b00, 2'b00, PCD, 1'b0);
        tick(); clr(); PCSrcW = 1'b1;
        expect_("pcsrc_w", 2'b00, 2'b00, FLD, 1'b0);
        tick(); clr(); BranchTakenE = 1'b1;
        expect_("branch", 2'b00, 2'b00, BR, 1'b0);

        // 3-cycle memory wait, hazards ignored while stalled
        tick(); clr(); MemAccessM = 1'b1;
        expect_("mw_idle", 2'b00, 2'b00, MEMS, 1'b0);
        tick(); BranchTakenE = 1'b1; MemtoRegE = 1'b1; WA3E = 4'd5; RA2D = 4'd5;
        expect_("mw_cnt1_br", 2'b00, 2'b00, MEMS, 1'b0);
        tick(); MemtoRegE = 1'b0; PCSrcW = 1'b1;
        expect_("mw_cnt2_br", 2'b00, 2'b00, MEMS, 1'b0);
        tick(); PCSrcW = 1'b0; mem_ready = 1'b1;
        expect_("mw_ready_br", 2'b00, 2'b00, BR, 1'b0);
        tick(); clr();
        expect_("mw_after", 2'b00, 2'b00, NONE, 1'b0);
        tick(); MemAccessM = 1'b1; mem_ready = 1'b1;
        expect_("ready_same_cycle", 2'b00, 2'b00, NONE, 1'b0);
        tick(); mem_ready = 1'b0;
        expect_("idle_after_ready", 2'b00, 2'b00, MEMS, 1'b0);
        tick(); mem_ready = 1'b1;
        expect_("wait_ready_c1", 2'b00, 2'b00, NONE, 1'b0);
        tick(); clr();
        expect_("idle_again", 2'b00, 2'b00, NONE, 1'b0);

        // timeout: IDLE + cnt 1..3 stall, release at cnt 4, mem_err next cycle only
        tick(); MemAccessM = 1'b1;
        expect_("to_idle", 2'b00, 2'b00, MEMS, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_($sformatf("to_cnt%0d", i), 2'b00, 2'b00, MEMS, 1'b0);
        end
        tick();
        expect_("to_release", 2'b00, 2'b00, NONE, 1'b0);
        tick(); clr();
        expect_("to_err_pulse", 2'b00, 2'b00, NONE, 1'b1);
        tick();
        expect_("to_err_gone", 2'b00, 2'b00, NONE, 1'b0);

        // ready on the timeout cycle wins
        tick(); MemAccessM = 1'b1;
        expect_("rw_idle", 2'b00, 2'b00, MEMS, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_($sformatf("rw_cnt%0d", i), 2'b00, 2'b00, MEMS, 1'b0);
        end
        tick(); mem_ready = 1'b1;
        expect_("rw_ready_at_to", 2'b00, 2'b00, NONE, 1'b0);
        tick(); clr();
        expect_("rw_no_err", 2'b00, 2'b00, NONE, 1'b0);

        // asynchronous reset clears a pending mem_err mid-cycle
        tick(); MemAccessM = 1'b1;
        expect_("ar_idle", 2'b00, 2'b00, MEMS, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_($sformatf("ar_cnt%0d", i), 2'b00, 2'b00, MEMS, 1'b0);
        end
        tick();
        expect_("ar_release", 2'b00, 2'b00, NONE, 1'b0);
        tick(); clr();
        expect_("ar_err_high", 2'b00, 2'b00, NONE, 1'b1);
        set_reset(1'b1);
        expect_("ar_err_cleared", 2'b00, 2'b00, NONE, 1'b0);
        tick(); set_reset(1'b0);
        expect_("ar_released", 2'b00, 2'b00, NONE, 1'b0);

        // reset mid-WAIT abandons the access, no pulse, counter restarts
        tick(); MemAccessM = 1'b1;
        expect_("rw2_idle", 2'b00, 2'b00, MEMS, 1'b0);
        tick();
        expect_("rw2_cnt1", 2'b00, 2'b00, MEMS, 1'b0);
        tick();
        expect_("rw2_cnt2", 2'b00, 2'b00, MEMS, 1'b0);
        set_reset(1'b1);
        expect_("rw2_in_reset", 2'b00, 2'b00, MEMS, 1'b0);
        tick(); clr();
        expect_("rw2_reset_idle", 2'b00, 2'b00, NONE, 1'b0);
        tick(); set_reset(1'b0);
        expect_("rw2_no_err", 2'b00, 2'b00, NONE, 1'b0);
        tick(); MemAccessM = 1'b1;
        expect_("rw2_restart", 2'b00, 2'b00, MEMS, 1'b0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            expect_($sformatf("rw2_cnt%0d_again", i), 2'b00, 2'b00, MEMS, 1'b0);
        end
        tick();
        expect_("rw2_release", 2'b00, 2'b00, NONE, 1'b0);
        tick(); clr();
        expect_("rw2_err_pulse", 2'b00, 2'b00, NONE, 1'b1);
        tick();
        expect_("rw2_err_gone", 2'b00, 2'b00, NONE, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
PIPELINE_HAZARD_CTRL -- requirements
Module: pipeline_hazard_ctrl

Interface
REQ-001 Parameter MEM_TIMEOUT, default 15, meaning maximum data-memory wait cycles before abort; legal range 1..255.
REQ-002 clk  input  1  pipeline clock; all state updates on the rising edge.
REQ-003 reset  input  1  asynchronous, active-high.
REQ-004 RA1D, RA2D  input  4 each  decode-stage source register numbers.
REQ-005 RA1E, RA2E, WA3E  input  4 each  execute-stage sources and destination.
REQ-006 WA3M, WA3W  input  4 each  memory- and writeback-stage destinations.
REQ-007 RegWriteM, RegWriteW, MemtoRegE  input  1 each  stage control bits.
REQ-008 PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE  input  1 each  PC-write pending flags.
REQ-009 MemAccessM, mem_ready  input  1 each  memory-stage load/store active; data memory response valid.
REQ-010 ForwardAE, ForwardBE  output  2 each  ALU operand source: 00 register file, 01 writeback, 10 memory stage.
REQ-011 StallF, StallD, StallE, StallM  output  1 each  hold the corresponding pipeline register.
REQ-012 FlushD, FlushE, FlushW  output  1 each  load a bubble into the corresponding pipeline register.
REQ-013 mem_err  output  1  one-cycle pulse on memory timeout.
REQ-014 stall_cnt  output  32  total stall cycles; present only with HAZARD_PERF_EN.

Function
REQ-015 Forwarding combinational: ForwardAE=10 if RegWriteM and WA3M==RA1E; else 01 if RegWriteW and WA3W==RA1E; else 00; ForwardBE identical on RA2E.
REQ-016 Source register 15 never forwarded; ForwardxE=00 whenever its RA is 15.
REQ-017 ldrStall = MemtoRegE and (WA3E==RA1D or WA3E==RA2D); PCWrPending = PCSrcD or PCSrcE or PCSrcM.
REQ-018 FSM states IDLE, WAIT; 8-bit wait counter cnt.
REQ-019 IDLE -> WAIT when MemAccessM and not mem_ready; cnt loads 1.
REQ-020 WAIT -> IDLE when mem_ready; cnt clears.
REQ-021 WAIT with not mem_ready and cnt<MEM_TIMEOUT: cnt increments, remain WAIT.
REQ-022 WAIT with not mem_ready and cnt==MEM_TIMEOUT: -> IDLE, mem_err=1 for exactly the next cycle, cnt clears.
REQ-023 memStall (combinational) = MemAccessM and not mem_ready and not (state==WAIT and cnt==MEM_TIMEOUT).
REQ-024 memStall=1: StallF=StallD=StallE=StallM=1, FlushW=1, FlushD=FlushE=0; all other hazards ignored.
REQ-025 memStall=0: StallF = ldrStall or PCWrPending; StallD = ldrStall; StallE=StallM=FlushW=0.
REQ-026 memStall=0: FlushD = PCWrPending or PCSrcW or BranchTakenE; FlushE = ldrStall or BranchTakenE.
REQ-027 mem_ready and MemAccessM in the same IDLE cycle: no stall, state stays IDLE.
REQ-028 mem_ready while WAIT in the cycle cnt==MEM_TIMEOUT: ready wins, mem_err not asserted.

Reset
REQ-029 reset asserted: state=IDLE, cnt=0, mem_err=0, stall_cnt=0 immediately, independent of clk.
REQ-030 Reset during WAIT abandons the access without a mem_err pulse.
REQ-031 Combinational outputs follow REQ-015..026 from inputs during reset, with state taken as IDLE.

Configuration
REQ-032 HAZARD_PERF_EN defined: stall_cnt increments each cycle StallF or StallM is 1, wraps 0xFFFFFFFF->0.
REQ-033 HAZARD_PERF_EN undefined: stall_cnt port and counter absent; all other behaviour identical.

Verification
REQ-034 RegWriteM=1, WA3M=3, RegWriteW=1, WA3W=3, RA1E=3 -> ForwardAE=10; repeat with RA1E=15 -> 00.
REQ-035 MemtoRegE=1, WA3E=5, RA2D=5 -> StallF=StallD=FlushE=1, StallE=0 for one cycle.
REQ-036 MemAccessM=1, mem_ready low 3 cycles then high -> StallM=FlushW=1 for 3 cycles, state IDLE after, mem_err=0.
REQ-037 MEM_TIMEOUT=4, mem_ready held low -> stall during the IDLE cycle plus cnt=1..3 WAIT cycles, released at cnt==4, mem_err pulses once.
REQ-038 BranchTakenE=1 coincident with a memStall -> FlushD=FlushE=0; after release, BranchTakenE=1 -> FlushD=FlushE=1.
REQ-039 Reset asserted mid-WAIT -> outputs return to IDLE values asynchronously; with HAZARD_PERF_EN, stall_cnt=0.
